// File: rtl/prog_counter.sv
// Prescaled up/down counter with wrap/saturate modes, load, tc and sticky ovf.
// Ports: clk, rst, en, dir, sat, load, load_val, limit, prescale, clr_ovf -> cnt, tc, ovf.
module prog_counter #(
  parameter int COUNTER_WIDTH = 32,
  parameter logic [COUNTER_WIDTH-1:0] INIT_CNT = '0,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      dir,
  input  logic                      sat,
  input  logic                      load,
  input  logic [COUNTER_WIDTH-1:0]  load_val,
  input  logic [COUNTER_WIDTH-1:0]  limit,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      clr_ovf,
  output logic [COUNTER_WIDTH-1:0]  cnt,
  output logic                      tc,
  output logic                      ovf
);

  localparam int W  = COUNTER_WIDTH;
  localparam int PW = PRESCALE_WIDTH;

  // Powers up at INIT_CNT so cnt is defined before the first reset.
  logic [W-1:0]  cnt_q = INIT_CNT;
  logic [PW-1:0] div_q;
  logic          tc_q;
  logic          ovf_q;

  logic          tick;
  logic          bnd;
  logic [W-1:0]  nxt;

  // ">=" also catches a prescale lowered below the running divider.
  assign tick = en && (div_q >= prescale);

  // Up at/above limit is a boundary, so cnt+1 never carries out.
  always_comb begin
    bnd = 1'b0;
    nxt = cnt_q;
    if (dir) begin
      if (cnt_q >= limit) begin
        bnd = 1'b1;
        nxt = sat ? limit : '0;
      end else begin
        nxt = cnt_q + W'(1);
      end
    end else begin
      if (cnt_q == '0) begin
        bnd = 1'b1;
        nxt = sat ? '0 : limit;
      end else begin
        nxt = cnt_q - W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= INIT_CNT;
      div_q <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else if (load) begin
      cnt_q <= load_val;
      div_q <= '0;
      tc_q  <= 1'b0;
      ovf_q <= ovf_q & ~clr_ovf;
    end else begin
      if (en) begin
        div_q <= tick ? '0 : div_q + PW'(1);
      end
      if (tick) begin
        cnt_q <= nxt;
      end
      tc_q  <= tick & bnd;
      // Set wins over a simultaneous clear.
      ovf_q <= (tick & bnd) | (ovf_q & ~clr_ovf);
    end
  end

  assign cnt = cnt_q;
  assign tc  = tc_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_prog_counter.sv
// Scoreboard bench for prog_counter: stimulus pushes expected cnt/tc/ovf,
// a monitor pops and compares one entry after each rising edge.
module tb_prog_counter;

  localparam int W    = 4;
  localparam int PW   = 3;
  localparam int INIT = 5;

  logic          clk;
  logic          rst;
  logic          en;
  logic          dir;
  logic          sat;
  logic          load;
  logic [W-1:0]  load_val;
  logic [W-1:0]  limit;
  logic [PW-1:0] prescale;
  logic          clr_ovf;
  logic [W-1:0]  cnt;
  logic          tc;
  logic          ovf;

  prog_counter #(
    .COUNTER_WIDTH (W),
    .INIT_CNT      (W'(INIT)),
    .PRESCALE_WIDTH(PW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .dir     (dir),
    .sat     (sat),
    .load    (load),
    .load_val(load_val),
    .limit   (limit),
    .prescale(prescale),
    .clr_ovf (clr_ovf),
    .cnt     (cnt),
    .tc      (tc),
    .ovf     (ovf)
  );

  typedef struct {
    int cnt;
    bit tc;
    bit ovf;
    int id;
  } exp_t;

  exp_t sbq[$];

  int n_cmp = 0;
  int n_bad = 0;
  int n_id  = 0;

  // Reference state: plain integers, updated straight from the rules.
  int m_cnt = INIT;
  int m_phase = 0;
  bit m_ovf = 0;
  bit m_tc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int req, input int id);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0d, want %0d", name, id, act, req);
    end
  endtask

  // Expected outputs after the coming rising edge, given current inputs.
  task automatic model();
    exp_t e;
    bit   tk;
    bit   hit;
    int   lim;
    lim = int'(limit);
    if (rst) begin
      m_cnt = INIT; m_phase = 0; m_tc = 0; m_ovf = 0;
    end else if (load) begin
      m_cnt = int'(load_val); m_phase = 0; m_tc = 0;
      m_ovf = m_ovf && !clr_ovf;
    end else begin
      tk = 0; hit = 0;
      if (en) begin
        // one step per (prescale+1) enabled cycles
        if (m_phase >= int'(prescale)) begin
          tk = 1; m_phase = 0;
        end else begin
          m_phase = m_phase + 1;
        end
      end
      if (tk) begin
        if (dir) begin
          hit = (m_cnt >= lim);
          m_cnt = hit ? (sat ? lim : 0) : m_cnt + 1;
        end else begin
          hit = (m_cnt == 0);
          m_cnt = hit ? (sat ? 0 : lim) : m_cnt - 1;
        end
      end
      m_tc = hit;
      m_ovf = hit || (m_ovf && !clr_ovf);
    end
    e.cnt = m_cnt;
    e.tc  = m_tc;
    e.ovf = m_ovf;
    e.id  = n_id++;
    sbq.push_back(e);
  endtask

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      model();
      @(negedge clk);
    end
  endtask

  task automatic do_load(input int v);
    load = 1'b1;
    load_val = W'(v);
    cyc();
    load = 1'b0;
  endtask

  // Monitor: one expected entry per clock edge while stimulus is active.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("cnt", int'(cnt), e.cnt, e.id);
        chk("tc", int'(tc), int'(e.tc), e.id);
        chk("ovf", int'(ovf), int'(e.ovf), e.id);
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; dir = 1'b1; sat = 1'b0;
    load = 1'b0; load_val = '0; limit = '1;
    prescale = '0; clr_ovf = 1'b0;
    #1;
    chk("powerup_cnt", int'(cnt), INIT, -1);
    cyc(2);
    rst = 1'b0;

    // Wrap up through full range.
    do_load(0);
    clr_ovf = 1'b1; cyc(); clr_ovf = 1'b0;
    en = 1'b1; limit = 4'd15; prescale = '0; dir = 1'b1; sat = 1'b0;
    cyc(17);

    // Prescale 2 with an enable gap mid-period.
    do_load(0);
    prescale = 3'd2;
    cyc(7);
    en = 1'b0; cyc(5);
    en = 1'b1; cyc(8);

    // Saturate down, then up to a small limit.
    prescale = '0; sat = 1'b1; dir = 1'b0;
    do_load(2);
    cyc(5);
    dir = 1'b1; limit = 4'd3;
    cyc(5);

    // Load above limit.
    sat = 1'b0; limit = 4'd5; dir = 1'b1;
    do_load(12);
    cyc(2);
    dir = 1'b0;
    do_load(12);
    cyc(14);

    // Reset beats load/clear/boundary tick.
    dir = 1'b1; limit = 4'd3;
    do_load(3);
    rst = 1'b1; load = 1'b1; load_val = 4'd9; clr_ovf = 1'b1;
    cyc();
    rst = 1'b0; load = 1'b0; clr_ovf = 1'b0;
    do_load(3);
    clr_ovf = 1'b1; cyc(); clr_ovf = 1'b0;
    cyc(2);

    // limit=0 in both modes and both directions.
    limit = '0;
    for (int m = 0; m < 4; m++) begin
      sat = m[0];
      dir = m[1];
      cyc(5);
    end

    // Prescale dropped below the running divider.
    limit = 4'd15; dir = 1'b1; sat = 1'b0;
    do_load(0);
    prescale = 3'd5; cyc(4);
    prescale = 3'd1; cyc(4);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      rst      = ($urandom_range(0, 99) < 2);
      load     = ($urandom_range(0, 99) < 6);
      load_val = W'($urandom_range(0, 15));
      en       = ($urandom_range(0, 99) < 80);
      clr_ovf  = ($urandom_range(0, 99) < 10);
      if ($urandom_range(0, 9) == 0) dir = ~dir;
      if ($urandom_range(0, 19) == 0) sat = ~sat;
      if ($urandom_range(0, 29) == 0)
        limit = W'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0)
        prescale = PW'($urandom_range(0, 3));
      cyc();
    end
    rst = 1'b0; load = 1'b0; en = 1'b0; clr_ovf = 1'b0;

    repeat (3) @(negedge clk);
    chk("sb_drained", sbq.size(), 0, n_id);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
